mig_tt_extract: RTL
===================

MIG_TT_EXTRACT -- requirements
Module: mig_tt_extract

Interface
REQ-001 NUM_GATES, 8, number of programmable majority gates w0..w7; fixed at 8 for this block.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cfg_valid  in  1  gate-descriptor write request.
REQ-005 cfg_ready  out  1  write accepted when cfg_valid&cfg_ready.
REQ-006 cfg_idx  in  3  gate index 0..7 to write.
REQ-007 cfg_gate  in  15  three 5-bit operands {c,b,a}; operand bit4 = invert, bits3:0 = source (0 = const0, 1..7 = x0..x6, 8..15 = w0..w7).
REQ-008 out_sel  in  4  output source, same 4-bit source encoding; sampled at start.
REQ-009 out_inv  in  1  complement output; sampled at start.
REQ-010 start  in  1  begin truth-table extraction; accepted only in IDLE.
REQ-011 busy  out  1  high in EVAL.
REQ-012 tt_valid  out  1  truth table available.
REQ-013 tt_ready  in  1  consumer accepts tt.
REQ-014 tt  out  128  extracted truth table; tt[m] = function value at minterm m.
REQ-015 err  out  1  forward-reference flag for the last extraction.

Function
REQ-016 Gate k SHALL compute MAJ(a',b',c'), each operand optionally inverted per bit4.
REQ-017 Operand referencing w_j with j>=k SHALL evaluate as const0 and set err for that run.
REQ-018 FSM states IDLE, EVAL, DONE; IDLE->EVAL on start; EVAL->DONE after minterm 127; DONE->IDLE on tt_valid&tt_ready.
REQ-019 cfg_ready SHALL equal (state==IDLE); writes in other states ignored.
REQ-020 cfg write and start in same cycle: both accepted; the write is visible to the run.
REQ-021 EVAL SHALL evaluate one minterm per cycle, m = 0..127, x_i = bit i of m, all gates combinational in index order.
REQ-022 tt[m] SHALL capture the selected source (xor out_inv) at the end of cycle m of EVAL.
REQ-023 Latency: tt_valid asserts exactly 129 cycles after the start-accept edge, and holds with tt stable until tt_ready.
REQ-024 tt_valid SHALL be low outside DONE; start ignored outside IDLE.
REQ-025 err SHALL clear on start accept and remain valid through DONE.
REQ-026 Minterm counter 7-bit, no wrap past 127 observable; terminal count triggers DONE.
REQ-027 tt retains previous contents until the next run overwrites it.

Reset
REQ-028 rst SHALL force IDLE, all gate descriptors to 0 (each gate = const0), latched out_sel/out_inv to 0, tt to 0, tt_valid/busy/err to 0, counter to 0.
REQ-029 rst mid-EVAL or in DONE SHALL abort the run with no tt_valid pulse.

Structure
REQ-030 Shared package mig_pkg: operand-field typedef, source-encoding constants (SRC_ZERO, SRC_X0, SRC_W0), NUM_GATES, TT_BITS=128.
REQ-031 One sub-module mig_gate_eval: combinational operand mux + invert + 3-input majority; instantiated 8 times.

Verification
REQ-032 After rst, start, tt_ready=1 -> tt=128'h0, err=0, tt_valid on cycle 129.
REQ-033 Gate0 = MAJ(x0,x0,0), out_sel=w0 -> tt=128'hAAAA...AAAA; same with out_inv=1 -> 128'h5555...5555.
REQ-034 Gates w0=MAJ(x3,x5,x6), w1=MAJ(x0,x1,x4), w2=MAJ(x4,x5,w0), w3=MAJ(x1,x3,w2), w4=MAJ(x2,w1,w3), w5=MAJ(x0,x5,w4), w6=MAJ(x6,w4,w5), out_sel=w6 -> tt=128'hfeeefaeafee0c880feecf880a8a08880.
REQ-035 Gate2 operand = w5 -> operand reads 0, err=1 at tt_valid.
REQ-036 tt_ready=0 for 20 cycles in DONE -> tt_valid and tt stable; cfg_valid ignored (cfg_ready=0); start ignored.
REQ-037 rst asserted at EVAL cycle 60 -> IDLE next cycle, tt=0, no tt_valid; subsequent run completes normally.

Source files
------------

// File: rtl/mig_pkg.sv
// Shared types and encodings for the majority-gate truth-table extractor.
// Source encoding: 0 = const0, 1..7 = x0..x6, 8..15 = w0..w7.
package mig_pkg;

  localparam int NUM_GATES = 8;
  localparam int NUM_VARS  = 7;
  localparam int TT_BITS   = 128;

  localparam logic [3:0] SRC_ZERO = 4'd0;
  localparam logic [3:0] SRC_X0   = 4'd1;
  localparam logic [3:0] SRC_W0   = 4'd8;

  typedef struct packed {
    logic       inv;
    logic [3:0] src;
  } operand_t;

  // Index 0 is operand a, 2 is operand c.
  typedef operand_t [2:0] gate_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Bit 0 of the pool is const0, so the raw 4-bit source code indexes it directly.
  function automatic logic src_value(input logic [3:0] src,
                                     input logic [NUM_VARS-1:0] x,
                                     input logic [NUM_GATES-1:0] w);
    logic [15:0] pool;
    pool = {w, x, 1'b0};
    return pool[src];
  endfunction

endpackage

// File: rtl/mig_gate_eval.sv
// One programmable majority gate: operand muxes, optional inversion, MAJ3.
// w_i only carries gates below K, so forward references already read as 0.
module mig_gate_eval
  import mig_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [NUM_VARS-1:0]  x_i,
  input  logic [NUM_GATES-1:0] w_i,
  input  gate_desc_t           gate_i,
  output logic                 y_o,
  output logic                 fwd_o
);

  logic [2:0] opv;
  logic [2:0] fwd;

  always_comb begin
    opv = 3'b000;
    fwd = 3'b000;
    for (int i = 0; i < 3; i++) begin
      opv[i] = src_value(gate_i[i].src, x_i, w_i) ^ gate_i[i].inv;
      fwd[i] = gate_i[i].src[3] && (int'(gate_i[i].src[2:0]) >= K);
    end
  end

  assign y_o   = maj3(opv[0], opv[1], opv[2]);
  assign fwd_o = |fwd;

endmodule

// File: rtl/mig_tt_extract.sv
// Sweeps all 128 minterms through a chain of 8 programmable majority gates
// and collects the selected output into a truth table.
module mig_tt_extract
  import mig_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_idx,
  input  logic [14:0]        cfg_gate,
  input  logic [3:0]         out_sel,
  input  logic               out_inv,
  input  logic               start,
  output logic               busy,
  output logic               tt_valid,
  input  logic               tt_ready,
  output logic [TT_BITS-1:0] tt,
  output logic               err
);

  state_t               state_q;
  logic [6:0]           cnt_q;
  gate_desc_t           gates_q [NUM_GATES];
  logic [3:0]           sel_q;
  logic                 inv_q;
  logic [TT_BITS-1:0]   tt_q;
  logic                 tt_valid_q;
  logic                 err_q;

  logic [NUM_GATES-1:0] w_all;
  logic [NUM_GATES-1:0] fwd_all;
  logic                 sel_bit;

  // Each gate sees only the outputs of lower-indexed gates.
  for (genvar k = 0; k < NUM_GATES; k++) begin : g_gate
    logic [NUM_GATES-1:0] avail;
    logic                 y;
    logic                 fwd;
    if (k == 0) begin : g_base
      assign avail = '0;
    end else begin : g_chain
      assign avail = g_gate[k-1].avail | (NUM_GATES'(g_gate[k-1].y) << (k - 1));
    end
    mig_gate_eval #(.K(k)) u_gate (
      .x_i   (cnt_q),
      .w_i   (avail),
      .gate_i(gates_q[k]),
      .y_o   (y),
      .fwd_o (fwd)
    );
    assign w_all[k]   = y;
    assign fwd_all[k] = fwd;
  end

  assign sel_bit = src_value(sel_q, cnt_q, w_all) ^ inv_q;

  // Control FSM, configuration store and truth-table capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 7'd0;
      sel_q      <= 4'd0;
      inv_q      <= 1'b0;
      tt_q       <= '0;
      tt_valid_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_GATES; i++) gates_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) gates_q[cfg_idx] <= gate_desc_t'(cfg_gate);
          if (start) begin
            state_q <= ST_EVAL;
            cnt_q   <= 7'd0;
            sel_q   <= out_sel;
            inv_q   <= out_inv;
            err_q   <= 1'b0;
          end
        end
        ST_EVAL: begin
          tt_q[cnt_q] <= sel_bit;
          if (|fwd_all) err_q <= 1'b1;
          if (cnt_q == 7'd127) state_q <= ST_DONE;
          else                 cnt_q   <= cnt_q + 7'd1;
        end
        ST_DONE: begin
          if (tt_valid_q && tt_ready) begin
            tt_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            tt_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_EVAL);
  assign tt_valid  = tt_valid_q;
  assign tt        = tt_q;
  assign err       = err_q;

endmodule
